// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment table,
// off-levels and the default digit index type.
package seg7_pkg;

    localparam int DEF_NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       AN_OFF  = 1'b1;

    typedef logic [$clog2(DEF_NUM_DIGITS)-1:0] digit_idx_t;

    // Active-low {g..a} patterns; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Pure combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for one nibble.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: tear-free word latching via a pending
// buffer, per-slot dead time, hex decode and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DIGIT_CYCLES = 32768,
    parameter int DEAD_CYCLES  = 256,
    parameter int BLANK_LZ     = 1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              a2g,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);
    localparam logic [TICK_W-1:0]     DEAD_LIM  = TICK_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_DARK   = {NUM_DIGITS{AN_OFF}};

    logic [TICK_W-1:0]       tick_r;
    logic [IDX_W-1:0]        idx_r;
    logic [TICK_W-1:0]       tick_nxt_s;
    logic [IDX_W-1:0]        idx_nxt_s;

    logic [4*NUM_DIGITS-1:0] pend_data_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pend_full_r;
    logic [4*NUM_DIGITS-1:0] disp_data_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;

    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              a2g_r;
    logic                    dp_r;
    logic                    frame_done_r;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic                    xfer_s;
    logic                    upper_zero_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic                    blank_s;
    logic [3:0]              nibble_s;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   an_sel_s;

    assign slot_end_s  = enable && (tick_r == TICK_LAST);
    assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

    // A full pending buffer frees up on the frame-end swap; while dark the
    // word goes straight through, so the block always accepts.
    assign data_ready = ~pend_full_r | frame_end_s | ~enable;
    assign xfer_s     = data_valid & data_ready;

    // Scan position next state: hold at digit 0 slot start while disabled.
    always_comb begin
        tick_nxt_s = tick_r;
        idx_nxt_s  = idx_r;
        if (!enable) begin
            tick_nxt_s = '0;
            idx_nxt_s  = '0;
        end else if (slot_end_s) begin
            tick_nxt_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_r <= '0;
            idx_r  <= '0;
        end else begin
            tick_r <= tick_nxt_s;
            idx_r  <= idx_nxt_s;
        end
    end

    // Pending/display buffers; display only changes at frame end or while dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data_r <= '0;
            pend_dp_r   <= '0;
            pend_full_r <= 1'b0;
            disp_data_r <= '0;
            disp_dp_r   <= '0;
        end else begin
            if (xfer_s) begin
                pend_data_r <= data;
                pend_dp_r   <= dp_mask;
            end
            if (!enable) begin
                pend_full_r <= 1'b0;
                if (xfer_s) begin
                    disp_data_r <= data;
                    disp_dp_r   <= dp_mask;
                end else if (pend_full_r) begin
                    disp_data_r <= pend_data_r;
                    disp_dp_r   <= pend_dp_r;
                end
            end else if (frame_end_s) begin
                pend_full_r <= xfer_s;
                if (pend_full_r) begin
                    disp_data_r <= pend_data_r;
                    disp_dp_r   <= pend_dp_r;
                end
            end else if (xfer_s) begin
                pend_full_r <= 1'b1;
            end
        end
    end

    // Digit i is a leading zero when it and every higher nibble are zero.
    always_comb begin
        upper_zero_s = 1'b1;
        lz_mask_s    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero_s = upper_zero_s & (disp_data_r[4*i +: 4] == 4'h0);
            if (i > 0) begin
                lz_mask_s[i] = upper_zero_s;
            end else begin
                lz_mask_s[i] = 1'b0;
            end
        end
    end

    assign nibble_s = disp_data_r[{idx_r, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

    // Blank decision and one-hot active-low anode select for the current slot.
    always_comb begin
        blank_s = (tick_r < DEAD_LIM) || !enable ||
                  ((BLANK_LZ != 0) && lz_mask_s[idx_r]);
        an_sel_s        = AN_DARK;
        an_sel_s[idx_r] = 1'b0;
    end

    // Registered display outputs, one cycle behind the scan position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r         <= AN_DARK;
            a2g_r        <= SEG_OFF;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            if (blank_s) begin
                an_r  <= AN_DARK;
                a2g_r <= SEG_OFF;
                dp_r  <= 1'b1;
            end else begin
                an_r  <= an_sel_s;
                a2g_r <= seg_s;
                dp_r  <= ~disp_dp_r[idx_r];
            end
        end
    end

    assign an         = an_r;
    assign a2g        = a2g_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with 8-cycle slots and 2-cycle dead time.
module tb_seg7_scan_driver;

    localparam int SLOT  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  a2g;
    logic        dp;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    logic [6:0]  seg_ref [16];

    // model of the frame: position within frame, displayed word, pending word
    int          m_pos;
    logic [31:0] m_disp;
    logic [7:0]  m_disp_dp;
    logic [31:0] m_pend;
    logic [7:0]  m_pend_dp;
    logic        m_pend_full;
    int          last_pos;

    seg7_scan_driver #(
        .NUM_DIGITS   (8),
        .DIGIT_CYCLES (SLOT),
        .DEAD_CYCLES  (DEAD),
        .BLANK_LZ     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .dp_mask    (dp_mask),
        .an         (an),
        .a2g        (a2g),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos       = 0;
        m_disp      = 32'h0;
        m_disp_dp   = 8'h0;
        m_pend      = 32'h0;
        m_pend_dp   = 8'h0;
        m_pend_full = 1'b0;
        last_pos    = -1;
    endtask

    // One clock: predict from the model, clock the DUT, compare, advance model.
    task automatic cycle();
        int          slot;
        int          t;
        logic        fe;
        logic        rdy;
        logic        xfer;
        logic        blank;
        logic [3:0]  nib;
        logic [31:0] upper;
        logic [7:0]  e_an;
        logic [6:0]  e_a2g;
        logic        e_dp;
        logic        e_fd;
        #1;
        if (reset) begin
            @(posedge clk);
            #1;
            chk("an_rst", an, 8'hFF);
            chk("a2g_rst", a2g, 7'h7F);
            chk("dp_rst", dp, 1'b1);
            chk("fd_rst", frame_done, 1'b0);
            model_reset();
        end else begin
            slot  = m_pos / SLOT;
            t     = m_pos % SLOT;
            fe    = enable && (m_pos == FRAME - 1);
            rdy   = !m_pend_full || fe || !enable;
            chk("data_ready", data_ready, rdy);
            xfer  = data_valid && rdy;
            upper = m_disp >> (4 * slot);
            nib   = upper[3:0];
            blank = (t < DEAD) || !enable || (slot > 0 && upper == 32'h0);
            e_an  = blank ? 8'hFF : ~(8'h01 << slot);
            e_a2g = blank ? 7'h7F : seg_ref[nib];
            e_dp  = blank ? 1'b1 : ~m_disp_dp[slot];
            e_fd  = fe;
            @(posedge clk);
            #1;
            chk("an", an, e_an);
            chk("a2g", a2g, e_a2g);
            chk("dp", dp, e_dp);
            chk("frame_done", frame_done, e_fd);
            last_pos = enable ? m_pos : -1;
            if (!enable) begin
                if (xfer) begin
                    m_disp    = data;
                    m_disp_dp = dp_mask;
                end else if (m_pend_full) begin
                    m_disp    = m_pend;
                    m_disp_dp = m_pend_dp;
                end
                m_pend_full = 1'b0;
                m_pos       = 0;
            end else begin
                if (fe && m_pend_full) begin
                    m_disp    = m_pend;
                    m_disp_dp = m_pend_dp;
                end
                if (xfer) begin
                    m_pend      = data;
                    m_pend_dp   = dp_mask;
                    m_pend_full = 1'b1;
                end else if (fe) begin
                    m_pend_full = 1'b0;
                end
                m_pos = (m_pos + 1) % FRAME;
            end
        end
    endtask

    // Advance until the last clocked cycle was frame position p (bounded).
    task automatic run_until(input int p);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (last_pos != p && n < 3 * FRAME);
        if (last_pos != p) begin
            checks++;
            failures++;
            $display("FAIL run_until got=%0d expected=%0d", last_pos, p);
        end
    endtask

    initial begin
        seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        reset      = 1'b1;
        enable     = 1'b0;
        data_valid = 1'b0;
        data       = 32'h0;
        dp_mask    = 8'h0;
        model_reset();
        #2;
        chk("lit_rst_an", an, 8'hFF);
        chk("lit_rst_a2g", a2g, 7'h7F);
        cycle();
        cycle();
        reset  = 1'b0;
        enable = 1'b1;
        chk("lit_rel_an", an, 8'hFF);
        cycle();
        chk("lit_pos0_an", an, 8'hFF);
        cycle();
        chk("lit_pos1_an", an, 8'hFF);
        cycle();
        chk("lit_pos2_an", an, 8'hFE);
        chk("lit_pos2_a2g", a2g, 7'b1000000);

        // single load mid slot 3
        run_until(27);
        data_valid = 1'b1;
        data       = 32'h1234_5678;
        dp_mask    = 8'h00;
        cycle();
        data_valid = 1'b0;
        run_until(58);
        chk("lit_old_slot7_an", an, 8'hFF);
        run_until(63);
        chk("lit_frame_done", frame_done, 1'b1);
        run_until(2);
        chk("lit_new_slot0_an", an, 8'hFE);
        chk("lit_new_slot0_a2g", a2g, 7'b0000000);
        run_until(58);
        chk("lit_new_slot7_an", an, 8'h7F);
        chk("lit_new_slot7_a2g", a2g, 7'b1111001);

        // two loads in one frame
        run_until(9);
        data_valid = 1'b1;
        data       = 32'h0000_00A0;
        dp_mask    = 8'h00;
        cycle();
        data       = 32'h89AB_CDEF;
        dp_mask    = 8'h04;
        run_until(61);
        #1;
        chk("lit_ready_blocked", data_ready, 1'b0);
        cycle();
        #1;
        chk("lit_ready_frame_end", data_ready, 1'b1);
        cycle();
        data_valid = 1'b0;
        run_until(2);
        chk("lit_a0_slot0_an", an, 8'hFE);
        chk("lit_a0_slot0_a2g", a2g, 7'b1000000);
        run_until(10);
        chk("lit_a0_slot1_an", an, 8'hFD);
        chk("lit_a0_slot1_a2g", a2g, 7'b0001000);
        run_until(42);
        chk("lit_a0_slot5_an", an, 8'hFF);
        run_until(18);
        chk("lit_dp_slot2_an", an, 8'hFB);
        chk("lit_dp_slot2_a2g", a2g, 7'b0100001);
        chk("lit_dp_slot2_dp", dp, 1'b0);
        run_until(26);
        chk("lit_dp_slot3_dp", dp, 1'b1);
        chk("lit_dp_slot3_a2g", a2g, 7'b1000110);

        // enable drop in slot 5, write-through while dark, re-enable
        run_until(44);
        enable = 1'b0;
        cycle();
        chk("lit_disable_an", an, 8'hFF);
        cycle();
        data_valid = 1'b1;
        data       = 32'h0000_0005;
        dp_mask    = 8'h00;
        cycle();
        data_valid = 1'b0;
        enable     = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("lit_reen_an", an, 8'hFE);
        chk("lit_reen_a2g", a2g, 7'b0010010);
        run_until(10);
        chk("lit_reen_slot1_an", an, 8'hFF);

        // asynchronous reset mid slot
        run_until(2);
        #3;
        reset = 1'b1;
        #1;
        chk("lit_async_an", an, 8'hFF);
        chk("lit_async_a2g", a2g, 7'h7F);
        chk("lit_async_dp", dp, 1'b1);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
        end
        chk("lit_after_rst_a2g", a2g, 7'b1000000);
        for (int i = 0; i < 12; i++) begin
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
